// File: rtl/drink_dispatch_ctrl.sv
// Multi-channel drink dispense controller: request arbitration, one-hot mechanism drive,
// completion via synchronised finish edge, per-channel stock tracking and timeout fault.
module drink_dispatch_ctrl #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned MAX_STOCK = 15,
  parameter int unsigned TIMEOUT   = 1000,
  localparam int unsigned SEL_W    = $clog2(N_CH),
  localparam int unsigned STK_W    = $clog2(MAX_STOCK + 1),
  localparam int unsigned TMR_W    = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [SEL_W-1:0] sel,
  output logic             req_ack,
  output logic             req_rej,
  output logic [N_CH-1:0]  drink_contral,
  input  logic [N_CH-1:0]  drink_out_fin,
  output logic             flag,
  output logic             done,
  output logic             fault,
  input  logic             fault_clr,
  input  logic             refill,
  input  logic [SEL_W-1:0] refill_ch,
  output logic [N_CH-1:0]  sold_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_FAULT
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [TMR_W-1:0]   timer_inc;
  logic [STK_W-1:0]   stock_q [N_CH];
  logic [N_CH-1:0]    sold_out_q;
  logic               ack_q, ack_d;
  logic               rej_q, rej_d;
  logic               done_q, done_d;
  logic [N_CH-1:0]    fin_s1_q, fin_s2_q, fin_s3_q;
  logic [N_CH-1:0]    fin_rise;
  logic               sel_ok;
  logic [STK_W-1:0]   sel_stock;
  logic               dec_en;

  assign fin_rise  = fin_s2_q & ~fin_s3_q;
  assign sel_ok    = 32'(sel) < N_CH;
  assign sel_stock = sel_ok ? stock_q[sel] : '0;
  assign timer_inc = (timer_q == TMR_W'(TIMEOUT)) ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    timer_d = timer_q;
    ack_d   = 1'b0;
    rej_d   = 1'b0;
    done_d  = 1'b0;
    dec_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (!sel_ok || sel_stock == '0) begin
            rej_d = 1'b1;
          end else begin
            ack_d   = 1'b1;
            ch_d    = sel;
            timer_d = '0;
            state_d = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        timer_d = timer_inc;
        // completion is checked first so a simultaneous timeout never faults
        if (fin_rise[ch_q]) begin
          done_d  = 1'b1;
          dec_en  = 1'b1;
          state_d = S_IDLE;
        end else if (timer_inc == TMR_W'(TIMEOUT)) begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        if (fault_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      timer_q  <= '0;
      ack_q    <= 1'b0;
      rej_q    <= 1'b0;
      done_q   <= 1'b0;
      fin_s1_q <= '0;
      fin_s2_q <= '0;
      fin_s3_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      timer_q  <= timer_d;
      ack_q    <= ack_d;
      rej_q    <= rej_d;
      done_q   <= done_d;
      fin_s1_q <= drink_out_fin;
      fin_s2_q <= fin_s1_q;
      fin_s3_q <= fin_s2_q;
    end
  end

  // refill takes priority over a completion decrement on the same channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        stock_q[i] <= STK_W'(MAX_STOCK);
      end
      sold_out_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (refill && 32'(refill_ch) == i) begin
          stock_q[i] <= STK_W'(MAX_STOCK);
        end else if (dec_en && 32'(ch_q) == i) begin
          stock_q[i] <= stock_q[i] - 1'b1;
        end
        sold_out_q[i] <= (stock_q[i] == '0);
      end
    end
  end

  assign req_ack       = ack_q;
  assign req_rej       = rej_q;
  assign done          = done_q;
  assign flag          = (state_q == S_IDLE);
  assign fault         = (state_q == S_FAULT);
  assign drink_contral = (state_q == S_DRIVE) ? (N_CH'(1) << ch_q) : '0;
  assign sold_out      = sold_out_q;

endmodule

// File: tb/tb_drink_dispatch_ctrl.sv
// Scoreboard bench for drink_dispatch_ctrl: expected events queued by the driver,
// popped by a negedge monitor whenever ack/rej/done/fault appears.
module tb_drink_dispatch_ctrl;

  localparam int N_CH      = 4;
  localparam int MAX_STOCK = 15;
  localparam int TIMEOUT   = 1000;

  localparam int K_ACK   = 0;
  localparam int K_REJ   = 1;
  localparam int K_DONE  = 2;
  localparam int K_FAULT = 3;

  typedef struct {
    int kind;
    int ch;
    int stk;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            req;
  logic [1:0]      sel;
  logic            req_ack;
  logic            req_rej;
  logic [N_CH-1:0] drink_contral;
  logic [N_CH-1:0] fin;
  logic            flag;
  logic            done;
  logic            fault;
  logic            fault_clr;
  logic            refill;
  logic [1:0]      refill_ch;
  logic [N_CH-1:0] sold_out;

  exp_t sb_q[$];
  int   stock_m [N_CH];
  int   n_chk;
  int   n_pass;
  logic fault_prev;
  int   ev_cnt;
  int   kind_obs;
  exp_t mon_e;

  drink_dispatch_ctrl #(
    .N_CH(N_CH),
    .MAX_STOCK(MAX_STOCK),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .sel(sel),
    .req_ack(req_ack),
    .req_rej(req_rej),
    .drink_contral(drink_contral),
    .drink_out_fin(fin),
    .flag(flag),
    .done(done),
    .fault(fault),
    .fault_clr(fault_clr),
    .refill(refill),
    .refill_ch(refill_ch),
    .sold_out(sold_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      fault_prev = 1'b0;
    end else begin
      ev_cnt = int'(req_ack) + int'(req_rej) + int'(done) + int'(fault && !fault_prev);
      fault_prev = fault;
      if (ev_cnt > 1) chk("exclusive_events", ev_cnt, 1);
      if (ev_cnt == 1) begin
        kind_obs = req_ack ? K_ACK : req_rej ? K_REJ : done ? K_DONE : K_FAULT;
        if (sb_q.size() == 0) begin
          chk("spurious_event", kind_obs, -1);
        end else begin
          mon_e = sb_q.pop_front();
          chk("event_kind", kind_obs, mon_e.kind);
          case (mon_e.kind)
            K_ACK: begin
              chk("ack_contral", int'(drink_contral), 1 << mon_e.ch);
              chk("ack_flag", int'(flag), 0);
            end
            K_DONE: begin
              chk("done_contral", int'(drink_contral), 0);
              chk("done_flag", int'(flag), 1);
              chk("done_stock", int'(dut.stock_q[mon_e.ch]), mon_e.stk);
            end
            K_REJ: chk("rej_contral", int'(drink_contral), 0);
            default: chk("fault_contral", int'(drink_contral), 0);
          endcase
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag, input int budget, output int lat);
    lat = 0;
    while (sb_q.size() != 0 && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    if (sb_q.size() != 0) begin
      chk(tag, sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic do_req(input int ch, input int kind);
    int lat;
    sb_q.push_back('{kind: kind, ch: ch, stk: 0});
    req = 1'b1;
    sel = 2'(ch);
    tick(1);
    req = 1'b0;
    wait_drain("req_timeout", 6, lat);
  endtask

  task automatic finish(input int ch);
    int lat;
    sb_q.push_back('{kind: K_DONE, ch: ch, stk: stock_m[ch]});
    fin[ch] = 1'b1;
    wait_drain("done_timeout", 10, lat);
    chk("done_latency_3to4", int'(lat >= 3 && lat <= 4), 1);
    fin[ch] = 1'b0;
    tick(3);
  endtask

  task automatic dispense(input int ch);
    stock_m[ch]--;
    do_req(ch, K_ACK);
    finish(ch);
  endtask

  function automatic int sold_vec();
    int v = 0;
    for (int i = 0; i < N_CH; i++) if (stock_m[i] == 0) v |= (1 << i);
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    int lat;
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    req = 1'b0;
    sel = '0;
    fin = '0;
    fault_clr = 1'b0;
    refill = 1'b0;
    refill_ch = '0;
    for (int i = 0; i < N_CH; i++) stock_m[i] = MAX_STOCK;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    chk("rst_flag", int'(flag), 1);
    chk("rst_contral", int'(drink_contral), 0);
    chk("rst_pulses", int'({req_ack, req_rej, done}), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_sold_out", int'(sold_out), 0);

    // single dispense on channel 2
    dispense(2);

    // drain channel 0 then reject
    for (int n = 0; n < MAX_STOCK; n++) dispense(0);
    tick(2);
    chk("sold_out_ch0", int'(sold_out), sold_vec());
    do_req(0, K_REJ);
    chk("rej_contral_idle", int'(drink_contral), 0);
    chk("rej_flag", int'(flag), 1);

    // timeout on channel 1
    do_req(1, K_ACK);
    sb_q.push_back('{kind: K_FAULT, ch: 1, stk: 0});
    cnt = 0;
    while (drink_contral != '0 && cnt < TIMEOUT + 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_len_ok", int'(cnt >= TIMEOUT - 1 && cnt <= TIMEOUT), 1);
    wait_drain("fault_timeout", 4, lat);
    chk("fault_set", int'(fault), 1);
    req = 1'b1;
    sel = 2'd1;
    tick(1);
    req = 1'b0;
    tick(3);
    chk("fault_flag", int'(flag), 0);
    chk("fault_contral", int'(drink_contral), 0);
    chk("fault_sticky", int'(fault), 1);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk("clr_flag", int'(flag), 1);
    chk("clr_fault", int'(fault), 0);
    chk("clr_stock1", int'(dut.stock_q[1]), stock_m[1]);

    // foreign finish edges ignored during channel 3 drive
    stock_m[3]--;
    do_req(3, K_ACK);
    fin[0] = 1'b1;
    tick(5);
    fin[1] = 1'b1;
    fin[0] = 1'b0;
    tick(5);
    fin[1] = 1'b0;
    tick(4);
    chk("foreign_contral", int'(drink_contral), 8);
    finish(3);
    chk("foreign_stock0", int'(dut.stock_q[0]), stock_m[0]);
    chk("foreign_stock1", int'(dut.stock_q[1]), stock_m[1]);

    // refill of a sold-out channel, then refill colliding with completion
    for (int n = 0; n < MAX_STOCK; n++) dispense(1);
    tick(2);
    chk("sold_out_ch1", int'(sold_out), sold_vec());
    refill_ch = 2'd1;
    refill = 1'b1;
    tick(1);
    refill = 1'b0;
    stock_m[1] = MAX_STOCK;
    tick(1);
    chk("refill_sold_out", int'(sold_out), sold_vec());
    do_req(1, K_ACK);
    sb_q.push_back('{kind: K_DONE, ch: 1, stk: MAX_STOCK});
    fin[1] = 1'b1;
    tick(2);
    refill = 1'b1;
    tick(1);
    refill = 1'b0;
    wait_drain("collide_timeout", 6, lat);
    fin[1] = 1'b0;
    tick(3);
    chk("collide_stock1", int'(dut.stock_q[1]), MAX_STOCK);

    // async reset mid-drive
    do_req(2, K_ACK);
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_contral", int'(drink_contral), 0);
    for (int i = 0; i < N_CH; i++) stock_m[i] = MAX_STOCK;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_flag", int'(flag), 1);
    chk("post_rst_fault", int'(fault), 0);
    chk("post_rst_sold_out", int'(sold_out), 0);
    for (int i = 0; i < N_CH; i++) chk("post_rst_stock", int'(dut.stock_q[i]), stock_m[i]);
    tick(2);
    chk("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
